// File: rtl/clk_rst_pkg.sv
// clk_rst_sequencer shared types and defaults.
// FSM encoding, clog2 helper, default timing constants.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_e;

  localparam int DIV_DEFAULT_C = 2;
  localparam int RST_DLY_C     = 2000;
  localparam int STAGGER_C     = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << r) < 64'(v)) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_rst_sequencer_if.sv
// Control/status bundle between the board top and the sequencer.
// master drives strobes and divisors, slave is the sequencer.
interface clk_rst_sequencer_if #(
  parameter int NUM_CH    = 4,
  parameter int DIV_WIDTH = 16
);

  logic                 i_soft_rst;
  logic [NUM_CH-1:0]    i_div_wr;
  logic [DIV_WIDTH-1:0] i_div_data;
  logic [NUM_CH-1:0]    o_rst_n;
  logic [NUM_CH-1:0]    o_ce;
  logic [NUM_CH-1:0]    o_tgl;
  logic                 o_ready;
  logic                 o_busy;

  modport master (
    output i_soft_rst, i_div_wr, i_div_data,
    input  o_rst_n, o_ce, o_tgl, o_ready, o_busy
  );

  modport slave (
    input  i_soft_rst, i_div_wr, i_div_data,
    output o_rst_n, o_ce, o_tgl, o_ready, o_busy
  );

endinterface

// File: rtl/clk_ce_div.sv
// One divided clock-enable channel with shadowed divisor.
// Divisor changes land only on a counter wrap.
module clk_ce_div
  import clk_rst_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int DIV_DEFAULT = DIV_DEFAULT_C
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rel_i,
  input  logic                 clr_i,
  input  logic                 wr_i,
  input  logic [DIV_WIDTH-1:0] data_i,
  output logic                 ce_o,
  output logic                 tgl_o
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DEF = DIV_WIDTH'(DIV_DEFAULT);

  logic [DIV_WIDTH-1:0] shadow_q, shadow_d;
  logic [DIV_WIDTH-1:0] active_q, active_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] nd, rl;
  logic run_q, run_d;
  logic ce_q, ce_d;
  logic tgl_q, tgl_d;

  // Next divisor, reload value and counter/enable next state.
  always_comb begin
    nd       = wr_i ? data_i : shadow_q;
    rl       = (nd <= ONE) ? '0 : nd - ONE;
    shadow_d = nd;
    active_d = active_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    ce_d     = 1'b0;
    tgl_d    = tgl_q;
    if (!rel_i || clr_i) begin
      active_d = nd;
      cnt_d    = '0;
      run_d    = 1'b0;
      tgl_d    = 1'b0;
    end else if (!run_q) begin
      // first released cycle acts as one step of the countdown
      run_d    = 1'b1;
      active_d = nd;
      if (rl == '0) begin
        ce_d  = 1'b1;
        tgl_d = ~tgl_q;
      end else begin
        cnt_d = rl - ONE;
      end
    end else if (cnt_q == '0) begin
      active_d = nd;
      cnt_d    = rl;
      ce_d     = 1'b1;
      tgl_d    = ~tgl_q;
    end else begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow_q <= DEF;
      active_q <= DEF;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      ce_q     <= 1'b0;
      tgl_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      ce_q     <= ce_d;
      tgl_q    <= tgl_d;
    end
  end

  assign ce_o  = ce_q;
  assign tgl_o = tgl_q;

endmodule

// File: rtl/clk_rst_sequencer.sv
// Staggered per-domain reset release plus divided clock enables.
// Sequencer FSM here, one clk_ce_div per channel.
module clk_rst_sequencer
  import clk_rst_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int DIV_DEFAULT = DIV_DEFAULT_C,
  parameter int RST_DLY     = RST_DLY_C,
  parameter int STAGGER     = STAGGER_C
) (
  input logic               i_brd_clk,
  input logic               i_reset_n,
  clk_rst_sequencer_if.slave bus
);

  localparam int SEQ_W = clog2(RST_DLY + NUM_CH * STAGGER + 1);
  localparam logic [SEQ_W-1:0] FIRST =
    SEQ_W'(RST_DLY);
  localparam logic [SEQ_W-1:0] LAST =
    SEQ_W'(RST_DLY + (NUM_CH - 1) * STAGGER);

  function automatic logic [SEQ_W-1:0] rel_at(input int k);
    return SEQ_W'(RST_DLY + k * STAGGER);
  endfunction

  seq_state_e        state_q;
  logic [SEQ_W-1:0]  seq_q;
  logic [SEQ_W-1:0]  seq_nx;
  logic [NUM_CH-1:0] rst_n_q;
  logic              ready_q;
  logic              busy_q;
  logic              clr;
  logic [NUM_CH-1:0] ce_w;
  logic [NUM_CH-1:0] tgl_w;

  assign clr    = bus.i_soft_rst && (state_q != ST_HOLD);
  assign seq_nx = seq_q + SEQ_W'(1);

  // Reset sequencing FSM with registered outputs.
  always_ff @(posedge i_brd_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_HOLD;
      seq_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (clr) begin
      state_q <= ST_WAIT;
      seq_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          state_q <= ST_WAIT;
          seq_q   <= '0;
          busy_q  <= 1'b1;
        end
        ST_WAIT, ST_RELEASE: begin
          seq_q <= seq_nx;
          for (int k = 0; k < NUM_CH; k++) begin
            if (seq_nx == rel_at(k)) rst_n_q[k] <= 1'b1;
          end
          if (seq_nx == LAST) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (seq_nx == FIRST) begin
            state_q <= ST_RELEASE;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_ce_div #(
      .DIV_WIDTH  (DIV_WIDTH),
      .DIV_DEFAULT(DIV_DEFAULT)
    ) u_div (
      .clk_i (i_brd_clk),
      .rst_ni(i_reset_n),
      .rel_i (rst_n_q[g]),
      .clr_i (clr),
      .wr_i  (bus.i_div_wr[g]),
      .data_i(bus.i_div_data),
      .ce_o  (ce_w[g]),
      .tgl_o (tgl_w[g])
    );
  end

  assign bus.o_rst_n = rst_n_q;
  assign bus.o_ce    = ce_w;
  assign bus.o_tgl   = tgl_w;
  assign bus.o_ready = ready_q;
  assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer at default parameters.
// Edge numbers count rising edges from reset release.
module tb_clk_rst_sequencer;

  logic clk;
  logic rst_n;
  int   edge_n;
  int   total;
  int   bad;

  clk_rst_sequencer_if #(.NUM_CH(4), .DIV_WIDTH(16)) bus();

  clk_rst_sequencer #(
    .NUM_CH     (4),
    .DIV_WIDTH  (16),
    .DIV_DEFAULT(2),
    .RST_DLY    (2000),
    .STAGGER    (16)
  ) dut (
    .i_brd_clk(clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @edge %0d obs=%0h exp=%0h",
             tag, edge_n, obs, exp);
    end
  endtask

  task automatic to_edge(input int e);
    while (edge_n < e) begin
      @(negedge clk);
      edge_n++;
    end
  endtask

  task automatic wr(input int e,
                    input logic [3:0] m,
                    input logic [15:0] d);
    to_edge(e - 1);
    bus.i_div_wr   = m;
    bus.i_div_data = d;
    to_edge(e);
    bus.i_div_wr   = '0;
    bus.i_div_data = '0;
  endtask

  task automatic chk_all_off(input logic busy);
    chk("rst_n", bus.o_rst_n, 4'h0);
    chk("ce", bus.o_ce, 4'h0);
    chk("tgl", bus.o_tgl, 4'h0);
    chk("ready", bus.o_ready, 1'b0);
    chk("busy", bus.o_busy, busy);
  endtask

  initial begin
    total = 0;
    bad = 0;
    edge_n = 0;
    rst_n = 1'b0;
    bus.i_soft_rst = 1'b0;
    bus.i_div_wr = '0;
    bus.i_div_data = '0;
    repeat (3) @(negedge clk);
    chk_all_off(1'b0);

    rst_n = 1'b1;
    @(negedge clk);
    edge_n = 0;
    chk("busy0", bus.o_busy, 1'b1);
    chk("rst0", bus.o_rst_n, 4'h0);

    wr(11, 4'b0010, 16'd4);
    wr(12, 4'b0001, 16'd10);
    wr(13, 4'b0100, 16'd5);

    to_edge(1999);
    chk("rst1999", bus.o_rst_n, 4'h0);
    chk("busy1999", bus.o_busy, 1'b1);
    to_edge(2000);
    chk("rst2000", bus.o_rst_n, 4'h1);
    to_edge(2015);
    chk("rst2015", bus.o_rst_n, 4'h1);
    to_edge(2016);
    chk("rst2016", bus.o_rst_n, 4'h3);
    to_edge(2019);
    chk("ce1_2019", bus.o_ce[1], 1'b0);
    to_edge(2020);
    chk("ce1_2020", bus.o_ce[1], 1'b1);
    chk("ce0_2020", bus.o_ce[0], 1'b1);
    to_edge(2021);
    chk("ce1_2021", bus.o_ce[1], 1'b0);
    to_edge(2023);
    chk("tgl1_2023", bus.o_tgl[1], 1'b1);
    to_edge(2024);
    chk("ce1_2024", bus.o_ce[1], 1'b1);
    chk("tgl1_2024", bus.o_tgl[1], 1'b0);
    to_edge(2031);
    chk("rst2031", bus.o_rst_n, 4'h3);
    to_edge(2032);
    chk("rst2032", bus.o_rst_n, 4'h7);

    wr(2034, 4'b0001, 16'd3);
    to_edge(2037);
    chk("ce0_2037", bus.o_ce[0], 1'b0);
    to_edge(2040);
    chk("ce0_2040", bus.o_ce[0], 1'b1);
    to_edge(2041);
    chk("ce0_2041", bus.o_ce[0], 1'b0);
    to_edge(2043);
    chk("ce0_2043", bus.o_ce[0], 1'b1);
    to_edge(2047);
    chk("rst2047", bus.o_rst_n, 4'h7);
    chk("ready2047", bus.o_ready, 1'b0);
    chk("busy2047", bus.o_busy, 1'b1);
    to_edge(2048);
    chk("rst2048", bus.o_rst_n, 4'hF);
    chk("ready2048", bus.o_ready, 1'b1);
    chk("busy2048", bus.o_busy, 1'b0);
    to_edge(2049);
    chk("ce0_2049", bus.o_ce[0], 1'b1);

    to_edge(2057);
    chk("ce2_2057", bus.o_ce[2], 1'b1);
    wr(2062, 4'b0100, 16'd7);
    chk("ce2_2062", bus.o_ce[2], 1'b1);
    to_edge(2067);
    chk("ce2_2067", bus.o_ce[2], 1'b0);
    to_edge(2069);
    chk("ce2_2069", bus.o_ce[2], 1'b1);

    wr(2070, 4'b1000, 16'd1);
    to_edge(2071);
    chk("ce3_2071", bus.o_ce[3], 1'b1);
    chk("tgl3_2071", bus.o_tgl[3], 1'b0);
    to_edge(2072);
    chk("ce3_2072", bus.o_ce[3], 1'b1);
    chk("tgl3_2072", bus.o_tgl[3], 1'b1);
    wr(2074, 4'b1000, 16'd0);
    to_edge(2075);
    chk("ce3_2075", bus.o_ce[3], 1'b1);
    chk("tgl3_2075", bus.o_tgl[3], 1'b0);
    to_edge(2076);
    chk("ce3_2076", bus.o_ce[3], 1'b1);
    chk("tgl3_2076", bus.o_tgl[3], 1'b1);

    to_edge(2099);
    bus.i_soft_rst = 1'b1;
    to_edge(2100);
    bus.i_soft_rst = 1'b0;
    chk_all_off(1'b1);
    to_edge(2101);
    chk("ce_2101", bus.o_ce, 4'h0);
    to_edge(4099);
    chk("rst4099", bus.o_rst_n, 4'h0);
    to_edge(4100);
    chk("rst4100", bus.o_rst_n, 4'h1);
    to_edge(4102);
    chk("ce0_4102", bus.o_ce[0], 1'b0);
    to_edge(4103);
    chk("ce0_4103", bus.o_ce[0], 1'b1);
    to_edge(4116);
    chk("rst4116", bus.o_rst_n, 4'h3);
    to_edge(4119);
    chk("ce1_4119", bus.o_ce[1], 1'b0);
    to_edge(4120);
    chk("ce1_4120", bus.o_ce[1], 1'b1);

    rst_n = 1'b0;
    bus.i_soft_rst = 1'b1;
    to_edge(4121);
    bus.i_soft_rst = 1'b0;
    chk_all_off(1'b0);
    to_edge(4122);
    rst_n = 1'b1;
    to_edge(4123);
    chk("busy4123", bus.o_busy, 1'b1);
    to_edge(6122);
    chk("rst6122", bus.o_rst_n, 4'h0);
    to_edge(6123);
    chk("rst6123", bus.o_rst_n, 4'h1);
    to_edge(6124);
    chk("ce0_6124", bus.o_ce[0], 1'b0);
    to_edge(6125);
    chk("ce0_6125", bus.o_ce[0], 1'b1);
    to_edge(6126);
    chk("ce0_6126", bus.o_ce[0], 1'b0);
    to_edge(6127);
    chk("ce0_6127", bus.o_ce[0], 1'b1);
    to_edge(6140);
    chk("ce1_6140", bus.o_ce[1], 1'b0);
    to_edge(6141);
    chk("ce1_6141", bus.o_ce[1], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_rst_sequencer.md
Name: clk_rst_sequencer

Overview:
Synthesizable, parametrised clock-enable and reset-sequencing block clocked from the board clock. It generates NUM_CH independent divided clock-enable pulses, each with a 50%-duty toggle output. It releases NUM_CH per-domain active-low resets in staggered order after a power-on delay. It sits at the top level between the board clock/reset pins and the peripheral domains (UART, SPI, I2C, SRAM, Ethernet glue).

Parameters:
NUM_CH, 4, number of channels (1..16)
DIV_WIDTH, 16, divisor width in bits
DIV_DEFAULT, 2, divisor loaded into every channel at reset
RST_DLY, 2000, cycles from reset deassertion to first channel release (>=1)
STAGGER, 16, cycles between successive channel releases (>=1)

Ports:
i_brd_clk  in  1  board clock; all logic is on its rising edge
i_reset_n  in  1  reset; synchronous, active-low
i_soft_rst  in  1  one-cycle pulse; restarts the reset sequence
i_div_wr  in  NUM_CH  per-channel divisor write strobe
i_div_data  in  DIV_WIDTH  divisor value, shared across channels
o_rst_n  out  NUM_CH  per-channel synchronous active-low reset
o_ce  out  NUM_CH  per-channel one-cycle clock-enable pulse
o_tgl  out  NUM_CH  per-channel toggle, flips on each o_ce
o_ready  out  1  high when all channels are released
o_busy  out  1  high while the sequence is in progress

Behaviour:
- Reset (i_reset_n=0 sampled on an edge):
  - FSM goes to HOLD.
  - o_rst_n=0, o_ce=0, o_tgl=0, o_ready=0, o_busy=0.
  - Sequence counter=0.
  - Every active and shadow divisor is set to DIV_DEFAULT.
  - Every channel counter is set to 0.
- FSM states:
  - HOLD -> WAIT when i_reset_n=1. This is edge 0. o_busy=1 from edge 0.
  - WAIT counts RST_DLY cycles, then -> RELEASE.
  - o_rst_n[0] rises on edge RST_DLY.
  - RELEASE sets o_rst_n[k] high on edge RST_DLY + k*STAGGER.
  - After o_rst_n[NUM_CH-1] rises -> RUN. o_ready=1 and o_busy=0 on that same edge.
  - RUN stays in RUN.
- Soft reset: i_soft_rst=1 in any non-HOLD state has these effects on the next edge:
  - all o_rst_n=0, o_ready=0
  - o_ce=0, o_tgl=0, all channel counters cleared
  - FSM -> WAIT with the counter at 0, so the full sequence repeats and o_rst_n[0] rises RST_DLY edges later
  - divisors are retained
- i_reset_n=0 has priority over i_soft_rst.
- Channel divider k:
  - Idle (counter 0, o_ce=0) while o_rst_n[k]=0.
  - Once released, the counter counts down from active_div-1 to 0.
  - o_ce[k] is registered and asserted for one cycle on the cycle the counter is 0. The counter then reloads active_div-1.
  - First o_ce[k] occurs active_div cycles after o_rst_n[k] rises.
  - Divisor 0 or 1: o_ce[k] is constantly 1 and o_tgl[k] toggles every cycle.
  - o_tgl[k] inverts on each o_ce[k] pulse, so its period is 2*active_div.
- Divisor update:
  - i_div_wr[k]=1 writes i_div_data to shadow[k].
  - shadow copies into active at the next reload (counter wrap), so the period never glitches.
  - A write on the same edge as a wrap takes effect for that reload.
  - Multiple strobes in one cycle write the same value to all flagged channels.
  - Writes are accepted in every state, including HOLD after i_reset_n goes high.
  - While o_rst_n[k]=0, shadow is copied to active immediately.
- Arithmetic:
  - Counters are DIV_WIDTH wide, unsigned.
  - The sequence counter width is clog2(RST_DLY + NUM_CH*STAGGER + 1).
  - No saturation is needed.

Decomposition:
- Shared package clk_rst_pkg holds:
  - FSM state encoding (HOLD, WAIT, RELEASE, RUN)
  - a clog2 function
  - default constants for DIV_DEFAULT, RST_DLY, STAGGER
- Sub-module clk_ce_div covers one channel: counter, shadow/active registers, o_ce, o_tgl. It is instantiated NUM_CH times in a generate loop.
- The sequencer FSM stays in the top module.

Test Plan:
- Defaults (RST_DLY=2000, STAGGER=16, NUM_CH=4), i_reset_n raised at edge 0 -> o_rst_n rises at edges 2000, 2016, 2032, 2048; o_ready=1 at edge 2048; o_busy high during edges 0..2047.
- Divisor 4 written to ch1 before release -> o_ce[1] pulses every 4 cycles, first 4 cycles after o_rst_n[1] rises; o_tgl[1] period is 8.
- Ch0 running at divisor 10, write 3 mid-period -> current 10-cycle period completes, then pulses every 3 cycles; no short period.
- Write on the exact wrap cycle (ch2 divisor 5 -> 7) -> next period is 7.
- Divisor 0 and 1 on ch3 -> o_ce[3] held 1 and o_tgl[3] toggles every cycle.
- i_soft_rst pulse in RUN -> next edge all o_rst_n=0, o_ce=0, o_ready=0; re-release 2000 edges later in stagger order; divisors kept.
- i_reset_n=0 during RELEASE with i_soft_rst=1 -> HOLD, all outputs 0, divisors back to DIV_DEFAULT.
